mem_arbiter: RTL and testbench

- Shares the single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (load/store).
- Sequences each access as issue → wait for memory ack → registered response. Generates per-port stalls.
- Kills in-flight fetches on a branch redirect.
- Data port has priority. A starvation counter guarantees IF forward progress.

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/arb_starve_ctr.sv | 26 ++
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the IF/MEM unified-memory arbiter.
`ifndef NOOP_INST
`define NOOP_INST 32'h0000_0013
`endif
`ifndef TRUE
`define TRUE 1'b1
`endif
`ifndef FALSE
`define FALSE 1'b0
`endif

package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_IF,
    WAIT_DM,
    WAIT_KILL
  } arb_state_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive data-port wins taken while a fetch was waiting.
module arb_starve_ctr #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int unsigned CTR_W = $clog2(STARVE_MAX + 1);

  logic [CTR_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + CTR_W'(1);
    end
  end

  assign at_max = (cnt == CTR_W'(STARVE_MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported memory between instruction fetch and load/store,
// one outstanding access at a time, with data priority and fetch starvation relief.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_rsp_vld,
  output logic [DATA_W-1:0] if_rsp_inst,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_rsp_vld,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  arb_state_t state_q, state_d;
  logic       grant_if, grant_dm;
  logic       if_done, dm_done;
  logic       elig_if, elig_dm;
  logic       at_max;
  logic       streak_inc, streak_clr;
  logic       op_we;

  // A port is never eligible in its own response cycle, so a held request is not re-granted.
  assign elig_if = if_req & ~if_flush & ~if_rsp_vld;
  assign elig_dm = dm_req & ~dm_rsp_vld;

  assign if_stall = if_req & ~if_rsp_vld;
  assign dm_stall = dm_req & ~dm_rsp_vld;

  assign streak_inc = grant_dm & if_req;
  assign streak_clr = (grant_dm & ~if_req) | grant_if;

  arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve_ctr (
    .clk    (clk),
    .rst    (rst),
    .inc    (streak_inc),
    .clr    (streak_clr),
    .at_max (at_max)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_if = `FALSE;
    grant_dm = `FALSE;
    if_done  = `FALSE;
    dm_done  = `FALSE;
    case (state_q)
      IDLE: begin
        if (elig_dm && !(elig_if && at_max)) begin
          grant_dm = `TRUE;
          state_d  = WAIT_DM;
        end else if (elig_if) begin
          grant_if = `TRUE;
          state_d  = WAIT_IF;
        end
      end
      WAIT_IF: begin
        // A redirect racing the ack drops the data outright; otherwise drain the kill.
        if (if_flush) begin
          state_d = mem_ack ? IDLE : WAIT_KILL;
        end else if (mem_ack) begin
          if_done = `TRUE;
          state_d = IDLE;
        end
      end
      WAIT_DM: begin
        if (mem_ack) begin
          dm_done = `TRUE;
          state_d = IDLE;
        end
      end
      WAIT_KILL: begin
        if (mem_ack) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // Memory command and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      op_we       <= 1'b0;
      if_rsp_vld  <= 1'b0;
      if_rsp_inst <= DATA_W'(`NOOP_INST);
      dm_rsp_vld  <= 1'b0;
      dm_rdata    <= '0;
    end else begin
      mem_req    <= grant_if | grant_dm;
      mem_we     <= grant_dm & dm_we;
      if_rsp_vld <= if_done;
      dm_rsp_vld <= dm_done;
      if (grant_dm) begin
        mem_addr  <= dm_addr & WORD_MASK;
        mem_wdata <= dm_wdata;
        op_we     <= dm_we;
      end else if (grant_if) begin
        mem_addr <= if_addr & WORD_MASK;
      end
      if (if_done) begin
        if_rsp_inst <= mem_rdata;
      end
      if (dm_done) begin
        dm_rdata <= op_we ? '0 : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned STARVE_MAX = 4;
  localparam logic [31:0] NOOP       = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, if_flush = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_ack = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
  logic        if_rsp_vld, if_stall, dm_rsp_vld, dm_stall, mem_req, mem_we;
  logic [31:0] if_rsp_inst, dm_rdata, mem_addr, mem_wdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rsp_vld(if_rsp_vld), .if_rsp_inst(if_rsp_inst), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rsp_vld(dm_rsp_vld), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Memory responder: acks ack_dly cycles after each mem_req.
  int          ack_dly = 1;
  int          ack_cnt = 0;
  logic [31:0] rd_val  = '0;
  logic [31:0] mem_data [logic [31:0]];

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_data.exists(a)) return mem_data[a];
    return a ^ 32'h5A5A_0000 ^ (a << 16);
  endfunction

  // Reference model: owner 0 = free, 1 = fetch, 2 = data, 3 = killed fetch.
  int          m_owner = 0;
  int          m_streak = 0;
  bit          m_op_we = 1'b0;
  logic        e_req = 1'b0, e_we = 1'b0, e_ifv = 1'b0, e_dmv = 1'b0;
  logic [31:0] e_addr = '0, e_wdata = '0, e_inst = NOOP, e_rdata = '0;

  task automatic step();
    logic        n_req, n_we, n_ifv, n_dmv;
    logic [31:0] n_addr, n_wdata, n_inst, n_rdata;
    int          n_owner, n_streak;
    bit          n_opwe, want_if, want_dm;
    n_req = 1'b0; n_we = 1'b0; n_ifv = 1'b0; n_dmv = 1'b0;
    n_addr = e_addr; n_wdata = e_wdata; n_inst = e_inst; n_rdata = e_rdata;
    n_owner = m_owner; n_streak = m_streak; n_opwe = m_op_we;
    if (rst) begin
      n_addr = '0; n_wdata = '0; n_inst = NOOP; n_rdata = '0;
      n_owner = 0; n_streak = 0; n_opwe = 1'b0;
    end else begin
      case (m_owner)
        0: begin
          want_if = if_req && !if_flush && !e_ifv;
          want_dm = dm_req && !e_dmv;
          if (want_dm && !(want_if && m_streak == STARVE_MAX)) begin
            n_owner = 2; n_req = 1'b1; n_we = dm_we; n_opwe = dm_we;
            n_addr = dm_addr & 32'hFFFF_FFFC; n_wdata = dm_wdata;
            n_streak = !if_req ? 0 : (m_streak < STARVE_MAX ? m_streak + 1 : m_streak);
          end else if (want_if) begin
            n_owner = 1; n_req = 1'b1; n_addr = if_addr & 32'hFFFF_FFFC; n_streak = 0;
          end
        end
        1: begin
          if (if_flush) n_owner = mem_ack ? 0 : 3;
          else if (mem_ack) begin n_ifv = 1'b1; n_inst = mem_rdata; n_owner = 0; end
        end
        2: if (mem_ack) begin n_dmv = 1'b1; n_rdata = m_op_we ? '0 : mem_rdata; n_owner = 0; end
        default: if (mem_ack) n_owner = 0;
      endcase
    end
    @(posedge clk);
    #1;
    cyc++;
    e_req = n_req; e_we = n_we; e_ifv = n_ifv; e_dmv = n_dmv;
    e_addr = n_addr; e_wdata = n_wdata; e_inst = n_inst; e_rdata = n_rdata;
    m_owner = n_owner; m_streak = n_streak; m_op_we = n_opwe;
    mem_ack = 1'b0;
    if (ack_cnt > 0) begin
      ack_cnt--;
      if (ack_cnt == 0) begin mem_ack = 1'b1; mem_rdata = rd_val; end
    end
    if (mem_req === 1'b1) begin
      ack_cnt = ack_dly;
      rd_val  = mem_read(mem_addr);
      if (mem_we === 1'b1) mem_data[mem_addr] = mem_wdata;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; if_req = 1'b0; if_flush = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; ack_cnt = 0; mem_ack = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    checks++; if (if_rsp_vld !== 1'b0 || dm_rsp_vld !== 1'b0) begin errors++; $display("FAIL reset_rsp_vld: got %b%b want 00", if_rsp_vld, dm_rsp_vld); end
    checks++; if (if_rsp_inst !== NOOP) begin errors++; $display("FAIL reset_if_inst: got %h want %h", if_rsp_inst, NOOP); end
    checks++; if (dm_rdata !== 32'h0) begin errors++; $display("FAIL reset_dm_rdata: got %h want 0", dm_rdata); end
    checks++; if (if_stall !== 1'b0 || dm_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b%b want 00", if_stall, dm_stall); end
  endtask

  task automatic test_if_fetch();
    do_reset();
    ack_dly = 1;
    mem_data[32'h10] = 32'h0040_0093;
    if_req = 1'b1; if_addr = 32'h0000_0013;
    #1;
    checks++; if (if_stall !== 1'b1) begin errors++; $display("FAIL fetch_stall_T: got %b want 1", if_stall); end
    step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0) begin
      errors++; $display("FAIL fetch_issue: got req=%b addr=%h we=%b want req=1 addr=00000010 we=0", mem_req, mem_addr, mem_we); end
    checks++; if (if_stall !== 1'b1) begin errors++; $display("FAIL fetch_stall_T1: got %b want 1", if_stall); end
    step();
    checks++; if (mem_req !== 1'b0 || if_rsp_vld !== 1'b0 || if_stall !== 1'b1) begin
      errors++; $display("FAIL fetch_T2: got req=%b vld=%b stall=%b want 0 0 1", mem_req, if_rsp_vld, if_stall); end
    step();
    checks++; if (if_rsp_vld !== 1'b1 || if_rsp_inst !== 32'h0040_0093) begin
      errors++; $display("FAIL fetch_rsp: got vld=%b inst=%h want 1 00400093", if_rsp_vld, if_rsp_inst); end
    checks++; if (if_stall !== 1'b0) begin errors++; $display("FAIL fetch_stall_T3: got %b want 0", if_stall); end
    if_req = 1'b0;
    step();
    checks++; if (if_rsp_vld !== 1'b0 || if_rsp_inst !== 32'h0040_0093) begin
      errors++; $display("FAIL fetch_hold: got vld=%b inst=%h want 0 00400093", if_rsp_vld, if_rsp_inst); end
  endtask

  task automatic test_contention();
    logic [31:0] first_addr, dm_rd;
    int n_issue, if_grants, dm_rsp_cyc, if_issue_cyc;
    bit got_if;
    do_reset();
    ack_dly = 1;
    mem_data[32'h100] = 32'h1234_5678;
    n_issue = 0; if_grants = 0; dm_rsp_cyc = -10; if_issue_cyc = -1; got_if = 1'b0;
    first_addr = '0; dm_rd = '0;
    if_req = 1'b1; if_addr = 32'h20; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    for (int i = 0; i < 34; i++) begin
      step();
      if (mem_req === 1'b1) begin
        n_issue++;
        if (n_issue == 1) first_addr = mem_addr;
        if (mem_addr == 32'h20) begin
          if_grants++;
          if (if_issue_cyc < 0) if_issue_cyc = cyc;
        end
      end
      if (dm_rsp_vld === 1'b1) begin dm_rsp_cyc = cyc; dm_rd = dm_rdata; dm_req = 1'b0; end
      if (if_rsp_vld === 1'b1) begin if_req = 1'b0; got_if = 1'b1; end
    end
    checks++; if (got_if !== 1'b1) begin errors++; $display("FAIL contend_timeout: got if_rsp=%b want 1", got_if); end
    checks++; if (first_addr !== 32'h100) begin errors++; $display("FAIL contend_dm_first: got %h want 00000100", first_addr); end
    checks++; if (dm_rd !== 32'h1234_5678) begin errors++; $display("FAIL contend_dm_rdata: got %h want 12345678", dm_rd); end
    checks++; if (if_issue_cyc != dm_rsp_cyc + 1) begin errors++; $display("FAIL contend_if_issue: got cycle %0d want %0d", if_issue_cyc, dm_rsp_cyc + 1); end
    checks++; if (if_grants != 1) begin errors++; $display("FAIL contend_if_grants: got %0d want 1", if_grants); end
  endtask

  task automatic test_flush();
    int ack_cyc, new_cyc, stale;
    logic [31:0] new_addr, inst;
    bit seen, got;
    do_reset();
    ack_dly = 4;
    mem_data[32'h80] = 32'hCAFE_0001;
    if_req = 1'b1; if_addr = 32'h40;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      step();
      if (mem_req === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL flush_first_issue: got %b want 1", seen); end
    if_flush = 1'b1; if_addr = 32'h80;
    step();
    if_flush = 1'b0;
    ack_cyc = -1; new_cyc = -1; stale = 0; new_addr = '0; inst = '0; got = 1'b0;
    for (int i = 0; i < 25 && !got; i++) begin
      if (mem_req === 1'b1 && new_cyc < 0) begin new_cyc = cyc; new_addr = mem_addr; end
      if (mem_ack === 1'b1 && ack_cyc < 0) ack_cyc = cyc;
      if (if_rsp_vld === 1'b1) begin
        if (new_cyc < 0) stale++;
        else begin got = 1'b1; inst = if_rsp_inst; if_req = 1'b0; end
      end
      if (!got) step();
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL flush_stale_rsp: got %0d responses want 0", stale); end
    checks++; if (ack_cyc < 0 || new_cyc != ack_cyc + 2) begin errors++; $display("FAIL flush_reissue: got cycle %0d want %0d", new_cyc, ack_cyc + 2); end
    checks++; if (new_addr !== 32'h80) begin errors++; $display("FAIL flush_new_addr: got %h want 00000080", new_addr); end
    checks++; if (got !== 1'b1 || inst !== 32'hCAFE_0001) begin errors++; $display("FAIL flush_new_rsp: got vld=%b inst=%h want 1 cafe0001", got, inst); end
  endtask

  task automatic test_starve();
    int runs[$];
    int dm_run;
    do_reset();
    ack_dly = 1;
    dm_run = 0;
    if_req = 1'b1; if_addr = 32'h300; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h8000;
    for (int i = 0; i < 200 && runs.size() < 2; i++) begin
      step();
      // Hide the fetch in the data response cycle so the data port keeps competing.
      if_flush = dm_rsp_vld;
      if (dm_rsp_vld === 1'b1) dm_addr = dm_addr + 32'd4;
      if (if_rsp_vld === 1'b1) if_addr = if_addr + 32'd4;
      if (mem_req === 1'b1) begin
        if (mem_addr[15]) dm_run++;
        else begin runs.push_back(dm_run); dm_run = 0; end
      end
    end
    if_req = 1'b0; dm_req = 1'b0; if_flush = 1'b0;
    checks++;
    if (runs.size() != 2) begin errors++; $display("FAIL starve_if_grants: got %0d want 2", runs.size()); end
    else begin
      checks++; if (runs[0] != STARVE_MAX) begin errors++; $display("FAIL starve_first_run: got %0d want %0d", runs[0], STARVE_MAX); end
      checks++; if (runs[1] != STARVE_MAX) begin errors++; $display("FAIL starve_after_clear: got %0d want %0d", runs[1], STARVE_MAX); end
    end
  endtask

  task automatic test_store();
    bit seen, got;
    do_reset();
    ack_dly = 2;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      step();
      if (mem_req === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h200) begin
      errors++; $display("FAIL store_issue: got req=%b we=%b addr=%h wdata=%h want 1 1 00000200 deadbeef", mem_req, mem_we, mem_addr, mem_wdata); end
    step();
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL store_pulse: got req=%b we=%b want 0 0", mem_req, mem_we); end
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      if (dm_rsp_vld === 1'b1) got = 1'b1;
      else step();
    end
    checks++; if (got !== 1'b1 || dm_rdata !== 32'h0) begin errors++; $display("FAIL store_rsp: got vld=%b rdata=%h want 1 00000000", got, dm_rdata); end
    dm_req = 1'b0; dm_we = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int late_rsp;
    bit seen;
    do_reset();
    ack_dly = 3;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h500;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      step();
      if (mem_req === 1'b1) seen = 1'b1;
    end
    step();
    rst = 1'b1; dm_req = 1'b0;
    step();
    rst = 1'b0;
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++; $display("FAIL midrst_mem: got req=%b we=%b addr=%h wdata=%h want all 0", mem_req, mem_we, mem_addr, mem_wdata); end
    checks++; if (dm_rsp_vld !== 1'b0 || if_rsp_vld !== 1'b0 || dm_rdata !== 32'h0 || if_rsp_inst !== NOOP) begin
      errors++; $display("FAIL midrst_rsp: got dv=%b iv=%b rdata=%h inst=%h want 0 0 0 %h", dm_rsp_vld, if_rsp_vld, dm_rdata, if_rsp_inst, NOOP); end
    late_rsp = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (dm_rsp_vld !== 1'b0 || mem_req !== 1'b0) late_rsp++;
    end
    checks++; if (late_rsp != 0) begin errors++; $display("FAIL midrst_late_ack: got %0d active cycles want 0", late_rsp); end
    ack_dly = 1;
    if_req = 1'b1; if_addr = 32'h600;
    step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h600) begin errors++; $display("FAIL midrst_idle: got req=%b addr=%h want 1 00000600", mem_req, mem_addr); end
    for (int i = 0; i < 4; i++) step();
    if_req = 1'b0;
    step();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      ack_dly = int'($urandom_range(1, 3));
      if (!if_req || if_rsp_vld) begin if_req = ($urandom_range(0, 2) != 0); if_addr = $urandom; end
      if_flush = ($urandom_range(0, 15) == 0);
      if (if_flush && if_req) if_addr = $urandom;
      if (!dm_req || dm_rsp_vld) begin
        dm_req = ($urandom_range(0, 2) != 0); dm_we = 1'($urandom_range(0, 1));
        dm_addr = $urandom; dm_wdata = $urandom;
      end
      step();
      checks++; if (mem_req !== e_req) begin errors++; $display("FAIL rand_mem_req @%0d: got %b want %b", cyc, mem_req, e_req); end
      if (e_req) begin
        checks++; if (mem_addr !== e_addr || mem_we !== e_we) begin
          errors++; $display("FAIL rand_mem_cmd @%0d: got addr=%h we=%b want %h %b", cyc, mem_addr, mem_we, e_addr, e_we); end
        if (e_we) begin
          checks++; if (mem_wdata !== e_wdata) begin errors++; $display("FAIL rand_mem_wdata @%0d: got %h want %h", cyc, mem_wdata, e_wdata); end
        end
      end
      checks++; if (if_rsp_vld !== e_ifv || if_rsp_inst !== e_inst) begin
        errors++; $display("FAIL rand_if_rsp @%0d: got %b %h want %b %h", cyc, if_rsp_vld, if_rsp_inst, e_ifv, e_inst); end
      checks++; if (dm_rsp_vld !== e_dmv || dm_rdata !== e_rdata) begin
        errors++; $display("FAIL rand_dm_rsp @%0d: got %b %h want %b %h", cyc, dm_rsp_vld, dm_rdata, e_dmv, e_rdata); end
      checks++; if (if_stall !== (if_req & ~e_ifv) || dm_stall !== (dm_req & ~e_dmv)) begin
        errors++; $display("FAIL rand_stall @%0d: got %b%b want %b%b", cyc, if_stall, dm_stall, if_req & ~e_ifv, dm_req & ~e_dmv); end
    end
    if_req = 1'b0; dm_req = 1'b0; if_flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_if_fetch();
    test_contention();
    test_flush();
    test_starve();
    test_store();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
